// File: rtl/icache_setassoc_pkg.sv
// Shared definitions for the set-associative instruction cache.
// Holds the replacement-policy selectors, the controller state encoding and
// helpers that derive array geometry from the cache parameters.
package icache_setassoc_pkg;

    localparam int SWAP_FIFO = 0;
    localparam int SWAP_LRU  = 1;
    localparam int ADDR_W    = 30;   // word address width
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REFILL,
        S_RESP
    } state_t;

    function automatic int tag_len(input int line_addr_len, input int set_addr_len);
        return ADDR_W - line_addr_len - set_addr_len;
    endfunction

    function automatic int line_size(input int line_addr_len);
        return 1 << line_addr_len;
    endfunction

    function automatic int set_size(input int set_addr_len);
        return 1 << set_addr_len;
    endfunction

    // Way index width; a direct-mapped cache still carries a 1-bit index.
    function automatic int way_w(input int way_cnt);
        return (way_cnt > 1) ? $clog2(way_cnt) : 1;
    endfunction

endpackage

// File: rtl/icache_setassoc_if.sv
// Fetch-side and refill-side bus of the instruction cache.
//   fetch : rd_req/addr/flush in, rd_data/rd_valid/stall out
//   refill: mem_rd_req/mem_addr out, mem_rvalid/mem_rdata in
// slave is the cache's view, master the view of the fetch stage + memory.
interface icache_setassoc_if;
    import icache_setassoc_pkg::*;

    logic              rd_req;
    logic [ADDR_W-1:0] addr;
    logic              flush;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              stall;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd_req, addr, flush, mem_rvalid, mem_rdata,
        output rd_data, rd_valid, stall, mem_rd_req, mem_addr
    );

    modport master (
        output rd_req, addr, flush, mem_rvalid, mem_rdata,
        input  rd_data, rd_valid, stall, mem_rd_req, mem_addr
    );

endinterface

// File: rtl/icache_repl.sv
// Per-set victim selector and replacement-state updater.
//   set        : set being looked up (IDLE) or filled (REFILL)
//   hit_upd    : a hit on hit_way was accepted (LRU ages only)
//   fill_upd   : fill of fill_way completed
//   victim_way : way to evict when the set has no invalid way
// FIFO keeps a round-robin pointer per set; LRU keeps an age per way where
// age WAY_CNT-1 marks the least recently used way.
module icache_repl
    import icache_setassoc_pkg::*;
#(
    parameter int SET_ADDR_LEN = 2,
    parameter int WAY_CNT      = 2,
    parameter int SWAP_POLICY  = SWAP_FIFO
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [SET_ADDR_LEN-1:0]       set,
    input  logic                          hit_upd,
    input  logic [way_w(WAY_CNT)-1:0]     hit_way,
    input  logic                          fill_upd,
    input  logic [way_w(WAY_CNT)-1:0]     fill_way,
    output logic [way_w(WAY_CNT)-1:0]     victim_way
);
    localparam int WAY_W    = way_w(WAY_CNT);
    localparam int SET_SIZE = set_size(SET_ADDR_LEN);
    localparam logic [WAY_W-1:0] MAX_AGE = WAY_W'(WAY_CNT - 1);

    logic [SET_SIZE-1:0][WAY_W-1:0]              ptr_q;
    logic [SET_SIZE-1:0][WAY_CNT-1:0][WAY_W-1:0] age_q;
    logic [WAY_W-1:0]                            lru_way;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            age_q <= '0;
        end else if (fill_upd) begin
            ptr_q[set] <= (ptr_q[set] == MAX_AGE) ? '0 : ptr_q[set] + 1'b1;
            for (int w = 0; w < WAY_CNT; w++) begin
                if (WAY_W'(w) == fill_way)
                    age_q[set][w] <= '0;
                else if (age_q[set][w] != MAX_AGE)
                    age_q[set][w] <= age_q[set][w] + 1'b1;
            end
        end else if (hit_upd) begin
            // Only ways younger than the hit way move back by one, which
            // keeps the ages a strict ranking once the set is full.
            for (int w = 0; w < WAY_CNT; w++) begin
                if (WAY_W'(w) == hit_way)
                    age_q[set][w] <= '0;
                else if (age_q[set][w] < age_q[set][hit_way])
                    age_q[set][w] <= age_q[set][w] + 1'b1;
            end
        end
    end

    always_comb begin
        lru_way = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--)
            if (age_q[set][w] == MAX_AGE) lru_way = WAY_W'(w);
        victim_way = (SWAP_POLICY == SWAP_LRU) ? lru_way : ptr_q[set];
    end

endmodule

// File: rtl/icache_setassoc.sv
// N-way set-associative instruction cache between IF and a word-serial
// memory port. Hits answer with one cycle latency; a miss stalls fetch,
// refills the whole line in ascending word order, then answers in RESP.
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : fetch request/response and line refill port
//   hit_cnt, miss_cnt   : accepted requests that hit / missed (wrapping)
module icache_setassoc
    import icache_setassoc_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int WAY_CNT       = 2,
    parameter int SWAP_POLICY   = SWAP_FIFO,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    icache_setassoc_if.slave     bus,
    output logic [CNT_WIDTH-1:0] hit_cnt,
    output logic [CNT_WIDTH-1:0] miss_cnt
);
    localparam int TAG_LEN   = tag_len(LINE_ADDR_LEN, SET_ADDR_LEN);
    localparam int LINE_SIZE = line_size(LINE_ADDR_LEN);
    localparam int SET_SIZE  = set_size(SET_ADDR_LEN);
    localparam int WAY_W     = way_w(WAY_CNT);

    logic [LINE_ADDR_LEN-1:0] word_off;
    logic [SET_ADDR_LEN-1:0]  set_idx;
    logic [TAG_LEN-1:0]       tag_in;
    assign {tag_in, set_idx, word_off} = bus.addr;

    // Storage; data and tags are qualified by valid_q and need no reset.
    logic [DATA_W-1:0]               data_q [SET_SIZE][WAY_CNT][LINE_SIZE];
    logic [TAG_LEN-1:0]              tag_q  [SET_SIZE][WAY_CNT];
    logic [SET_SIZE-1:0][WAY_CNT-1:0] valid_q;

    state_t                   state_q, state_d;
    logic                     flush_pend_q;
    logic [LINE_ADDR_LEN-1:0] word_cnt_q, req_off_q;
    logic [WAY_W-1:0]         fill_way_q;
    logic [DATA_W-1:0]        rd_data_q;
    logic                     rd_valid_q, mem_rd_req_q;
    logic [ADDR_W-1:0]        mem_addr_q;

    // The outstanding miss is identified by its line address.
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [TAG_LEN-1:0]       req_tag;
    assign req_set = mem_addr_q[LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign req_tag = mem_addr_q[LINE_ADDR_LEN + SET_ADDR_LEN +: TAG_LEN];

    logic [WAY_CNT-1:0] hit_vec;
    logic               hit, inv_found;
    logic [WAY_W-1:0]   hit_way, inv_way, victim_way, repl_set_way_unused;
    logic [SET_ADDR_LEN-1:0] repl_set;
    logic               accept_hit, accept_miss, do_flush, stall, refill_beat, last_word;

    for (genvar w = 0; w < WAY_CNT; w++) begin : g_cmp
        assign hit_vec[w] = valid_q[set_idx][w] && (tag_q[set_idx][w] == tag_in);
    end
    assign hit = |hit_vec;

    always_comb begin
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAY_CNT - 1; w >= 0; w--) begin
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[set_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end
    assign repl_set_way_unused = '0;

    assign refill_beat = (state_q == S_REFILL) && bus.mem_rvalid;
    assign last_word   = refill_beat && (word_cnt_q == LINE_ADDR_LEN'(LINE_SIZE - 1));
    assign repl_set    = (state_q == S_REFILL) ? req_set : set_idx;

    icache_repl #(
        .SET_ADDR_LEN (SET_ADDR_LEN),
        .WAY_CNT      (WAY_CNT),
        .SWAP_POLICY  (SWAP_POLICY)
    ) u_repl (
        .clk        (clk),
        .rst_n      (rst_n),
        .set        (repl_set),
        .hit_upd    (accept_hit),
        .hit_way    (hit_way),
        .fill_upd   (last_word),
        .fill_way   (fill_way_q),
        .victim_way (victim_way)
    );

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        accept_hit  = 1'b0;
        accept_miss = 1'b0;
        do_flush    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Nothing is accepted while reset is held, so stall stays low.
                if (rst_n) begin
                    if (bus.flush || flush_pend_q) begin
                        do_flush = 1'b1;
                        stall    = 1'b1;
                    end else if (bus.rd_req) begin
                        if (hit) begin
                            accept_hit = 1'b1;
                        end else begin
                            accept_miss = 1'b1;
                            stall       = 1'b1;
                            state_d     = S_REFILL;
                        end
                    end
                end
            end
            S_REFILL: begin
                stall = 1'b1;
                if (last_word) state_d = S_RESP;
            end
            S_RESP: begin
                stall   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            word_cnt_q   <= '0;
            req_off_q    <= '0;
            fill_way_q   <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= '0;
            hit_cnt      <= '0;
            miss_cnt     <= '0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= accept_hit || last_word;
            if (accept_hit) begin
                rd_data_q <= data_q[set_idx][hit_way][word_off];
                hit_cnt   <= hit_cnt + 1'b1;
            end
            if (accept_miss) begin
                miss_cnt     <= miss_cnt + 1'b1;
                mem_rd_req_q <= 1'b1;
                mem_addr_q   <= {tag_in, set_idx, LINE_ADDR_LEN'(0)};
                req_off_q    <= word_off;
                fill_way_q   <= inv_found ? inv_way : victim_way;
                word_cnt_q   <= '0;
            end
            if (refill_beat) word_cnt_q <= word_cnt_q + 1'b1;
            if (last_word) begin
                // Earlier words are already in the array; the last one is
                // only on the bus this cycle.
                rd_data_q <= (req_off_q == word_cnt_q) ? bus.mem_rdata
                                                       : data_q[req_set][fill_way_q][req_off_q];
                valid_q[req_set][fill_way_q] <= 1'b1;
                mem_rd_req_q <= 1'b0;
            end
            if (do_flush) valid_q <= '0;
            // A flush seen while busy is replayed once the controller is idle.
            flush_pend_q <= do_flush ? 1'b0 : (flush_pend_q || (bus.flush && state_q != S_IDLE));
        end
    end

    always_ff @(posedge clk) begin
        if (refill_beat) data_q[req_set][fill_way_q][word_cnt_q] <= bus.mem_rdata;
        if (last_word)   tag_q[req_set][fill_way_q] <= req_tag;
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.stall      = stall;
    assign bus.mem_rd_req = mem_rd_req_q;
    assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache_setassoc.sv
module tb_icache_setassoc;
    import icache_setassoc_pkg::*;

    localparam int LINE = 8;
    localparam int SETS = 4;
    localparam int WAYS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] hit_f, miss_f, hit_l, miss_l;
    int          checks = 0;
    int          errors = 0;
    bit          use_lru = 1'b0;

    icache_setassoc_if bus_f();
    icache_setassoc_if bus_l();
    virtual icache_setassoc_if vif;

    icache_setassoc #(.SWAP_POLICY(SWAP_FIFO)) dut_fifo (
        .clk(clk), .rst_n(rst_n), .bus(bus_f), .hit_cnt(hit_f), .miss_cnt(miss_f));
    icache_setassoc #(.SWAP_POLICY(SWAP_LRU)) dut_lru (
        .clk(clk), .rst_n(rst_n), .bus(bus_l), .hit_cnt(hit_l), .miss_cnt(miss_l));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: memory contents and per-set residency lists
    // (front = next to evict; FIFO keeps fill order, LRU moves hits to back).
    int unsigned mq [SETS][$];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        return {2'b00, a} + 32'h90;
    endfunction

    function automatic bit model_access(input bit lru, input int s, input int unsigned t);
        for (int i = 0; i < mq[s].size(); i++) begin
            if (mq[s][i] == t) begin
                if (lru) begin
                    mq[s].delete(i);
                    mq[s].push_back(t);
                end
                return 1'b1;
            end
        end
        if (mq[s].size() == WAYS) void'(mq[s].pop_front());
        mq[s].push_back(t);
        return 1'b0;
    endfunction

    function automatic logic [31:0] cur_hits();
        return use_lru ? hit_l : hit_f;
    endfunction

    function automatic logic [31:0] cur_miss();
        return use_lru ? miss_l : miss_f;
    endfunction

    task automatic sel(input bit lru);
        use_lru = lru;
        if (lru) vif = bus_l;
        else     vif = bus_f;
    endtask

    task automatic idle_inputs();
        bus_f.rd_req = 1'b0; bus_f.addr = '0; bus_f.flush = 1'b0;
        bus_f.mem_rvalid = 1'b0; bus_f.mem_rdata = '0;
        bus_l.rd_req = 1'b0; bus_l.addr = '0; bus_l.flush = 1'b0;
        bus_l.mem_rvalid = 1'b0; bus_l.mem_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One fetch on the selected cache, serving a refill if it misses.
    // Starts and returns just after a falling edge with the cache idle.
    task automatic fetch(input logic [29:0] a, input int flush_at, input bit gaps,
                         output logic [31:0] d, output logic vld, output bit miss,
                         output logic [29:0] maddr, output bit mreq_bad);
        mreq_bad = 1'b0;
        maddr    = '0;
        vif.addr = a; vif.rd_req = 1'b1; vif.flush = 1'b0;
        #1;
        miss = vif.stall;
        @(negedge clk);
        if (miss) begin
            maddr = vif.mem_addr;
            for (int k = 0; k < LINE; k++) begin
                if (gaps && $urandom_range(0, 2) == 0) begin
                    vif.mem_rvalid = 1'b0; vif.mem_rdata = $urandom; vif.flush = 1'b0;
                    if (vif.mem_rd_req !== 1'b1 || vif.stall !== 1'b1) mreq_bad = 1'b1;
                    @(negedge clk);
                end
                if (vif.mem_rd_req !== 1'b1 || vif.stall !== 1'b1) mreq_bad = 1'b1;
                vif.mem_rvalid = 1'b1;
                vif.mem_rdata  = mem_word(maddr + 30'(k));
                vif.flush      = (k == flush_at);
                @(negedge clk);
            end
            vif.mem_rvalid = 1'b0; vif.flush = 1'b0; vif.rd_req = 1'b0;
            if (vif.mem_rd_req !== 1'b0) mreq_bad = 1'b1;
            d = vif.rd_data; vld = vif.rd_valid;
            @(negedge clk);
        end else begin
            vif.rd_req = 1'b0;
            d = vif.rd_data; vld = vif.rd_valid;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_f.rd_valid !== 1'b0 || bus_l.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rd_valid: got %b/%b want 0", bus_f.rd_valid, bus_l.rd_valid);
        end
        checks++;
        if (bus_f.rd_data !== 32'd0 || bus_l.rd_data !== 32'd0) begin
            errors++; $display("FAIL reset_rd_data: got %h/%h want 0", bus_f.rd_data, bus_l.rd_data);
        end
        checks++;
        if (bus_f.stall !== 1'b0 || bus_f.mem_rd_req !== 1'b0 || bus_f.mem_addr !== 30'd0) begin
            errors++; $display("FAIL reset_mem: stall %b req %b addr %h want 0/0/0",
                               bus_f.stall, bus_f.mem_rd_req, bus_f.mem_addr);
        end
        checks++;
        if (hit_f !== 0 || miss_f !== 0 || hit_l !== 0 || miss_l !== 0) begin
            errors++; $display("FAIL reset_counters: got %0d %0d %0d %0d want 0", hit_f, miss_f, hit_l, miss_l);
        end
    endtask

    task automatic test_miss_refill();
        logic [31:0] d; logic vld; bit miss, bad; logic [29:0] ma;
        sel(1'b0);
        do_reset();
        fetch(30'h10, -1, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b1) begin errors++; $display("FAIL miss_stall: stall %b want 1", miss); end
        checks++;
        if (ma !== 30'h10) begin errors++; $display("FAIL miss_mem_addr: got %h want 10", ma); end
        checks++;
        if (bad) begin errors++; $display("FAIL miss_mem_req: request/stall level wrong during refill"); end
        checks++;
        if (vld !== 1'b1 || d !== 32'hA0) begin
            errors++; $display("FAIL miss_resp: valid %b data %h want 1/a0", vld, d);
        end
        checks++;
        if (cur_miss() !== 32'd1 || cur_hits() !== 32'd0) begin
            errors++; $display("FAIL miss_count: miss %0d hit %0d want 1/0", cur_miss(), cur_hits());
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 7; i++) begin
            if (i < 7) begin
                vif.addr = 30'h11 + 30'(i); vif.rd_req = 1'b1;
                #1;
                checks++;
                if (vif.stall !== 1'b0 || vif.mem_rd_req !== 1'b0) begin
                    errors++; $display("FAIL b2b_stall[%0d]: stall %b req %b want 0/0", i, vif.stall, vif.mem_rd_req);
                end
            end else begin
                vif.rd_req = 1'b0;
            end
            if (i > 0) begin
                checks++;
                if (vif.rd_valid !== 1'b1 || vif.rd_data !== 32'hA0 + 32'(i)) begin
                    errors++; $display("FAIL b2b_data[%0d]: valid %b data %h want 1/%h",
                                       i, vif.rd_valid, vif.rd_data, 32'hA0 + 32'(i));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (vif.rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %b want 0", vif.rd_valid); end
        checks++;
        if (cur_hits() !== 32'd7 || cur_miss() !== 32'd1) begin
            errors++; $display("FAIL b2b_count: hit %0d miss %0d want 7/1", cur_hits(), cur_miss());
        end
    endtask

    // Runs a list of fetches on the selected cache and compares the
    // hit/miss outcome and returned word with the given expectations.
    task automatic test_sequence(input string name, input logic [29:0] addrs[6],
                                 input bit exp_miss[6], input int n);
        logic [31:0] d; logic vld; bit miss, bad; logic [29:0] ma;
        for (int i = 0; i < n; i++) begin
            fetch(addrs[i], -1, 1'b0, d, vld, miss, ma, bad);
            checks++;
            if (miss !== exp_miss[i] || vld !== 1'b1 || d !== mem_word(addrs[i])) begin
                errors++; $display("FAIL %s[%0d]: miss %b valid %b data %h want %b/1/%h",
                                   name, i, miss, vld, d, exp_miss[i], mem_word(addrs[i]));
            end
        end
    endtask

    task automatic test_fifo();
        logic [29:0] a[6] = '{30'h20, 30'h40, 30'h60, 30'h20, 30'h40, 30'h0};
        bit          m[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        sel(1'b0);
        do_reset();
        test_sequence("fifo", a, m, 5);
    endtask

    task automatic test_lru();
        logic [29:0] a[6] = '{30'h20, 30'h41, 30'h22, 30'h63, 30'h24, 30'h45};
        bit          m[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        sel(1'b1);
        do_reset();
        test_sequence("lru", a, m, 6);
    endtask

    // Follows test_fifo: lines 0x20 and 0x40 are resident in set 0.
    task automatic test_flush_idle();
        logic [31:0] d, h0, m0; logic vld; bit miss, bad; logic [29:0] ma;
        sel(1'b0);
        fetch(30'h21, -1, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b0 || d !== mem_word(30'h21)) begin
            errors++; $display("FAIL flush_pre_hit: miss %b data %h want 0/%h", miss, d, mem_word(30'h21));
        end
        h0 = hit_f; m0 = miss_f;
        vif.addr = 30'h21; vif.rd_req = 1'b1; vif.flush = 1'b1;
        #1;
        checks++;
        if (vif.stall !== 1'b1) begin errors++; $display("FAIL flush_stall: got %b want 1", vif.stall); end
        @(negedge clk);
        vif.flush = 1'b0; vif.rd_req = 1'b0;
        checks++;
        if (vif.rd_valid !== 1'b0 || hit_f !== h0 || miss_f !== m0) begin
            errors++; $display("FAIL flush_no_accept: valid %b hit %0d miss %0d want 0/%0d/%0d",
                               vif.rd_valid, hit_f, miss_f, h0, m0);
        end
        fetch(30'h21, -1, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b1 || d !== mem_word(30'h21)) begin
            errors++; $display("FAIL flush_post_miss: miss %b data %h want 1/%h", miss, d, mem_word(30'h21));
        end
    endtask

    task automatic test_flush_refill();
        logic [31:0] d; logic vld; bit miss, bad; logic [29:0] ma;
        sel(1'b1);
        do_reset();
        fetch(30'h2F, 3, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b1 || vld !== 1'b1 || d !== mem_word(30'h2F) || bad) begin
            errors++; $display("FAIL flush_refill_resp: miss %b valid %b data %h want 1/1/%h",
                               miss, vld, d, mem_word(30'h2F));
        end
        #1;
        checks++;
        if (vif.stall !== 1'b1) begin errors++; $display("FAIL flush_pending_stall: got %b want 1", vif.stall); end
        @(negedge clk);
        #1;
        checks++;
        if (vif.stall !== 1'b0) begin errors++; $display("FAIL flush_pending_done: got %b want 0", vif.stall); end
        fetch(30'h2F, -1, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b1) begin errors++; $display("FAIL flush_refill_miss: miss %b want 1", miss); end
    endtask

    task automatic test_reset_mid_refill();
        logic [31:0] d; logic vld; bit miss, bad; logic [29:0] ma;
        sel(1'b0);
        do_reset();
        vif.addr = 30'h10; vif.rd_req = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            vif.mem_rvalid = 1'b1; vif.mem_rdata = 32'hDEAD0000 + 32'(k);
            @(negedge clk);
        end
        vif.mem_rvalid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (vif.mem_rd_req !== 1'b0 || vif.stall !== 1'b0) begin
            errors++; $display("FAIL rst_mid: req %b stall %b want 0/0", vif.mem_rd_req, vif.stall);
        end
        @(negedge clk);
        rst_n = 1'b1; vif.rd_req = 1'b0;
        @(negedge clk);
        fetch(30'h10, -1, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b1 || ma !== 30'h10 || d !== 32'hA0 || cur_miss() !== 32'd1) begin
            errors++; $display("FAIL rst_refetch: miss %b addr %h data %h cnt %0d want 1/10/a0/1",
                               miss, ma, d, cur_miss());
        end
        fetch(30'h13, -1, 1'b0, d, vld, miss, ma, bad);
        checks++;
        if (miss !== 1'b0 || d !== 32'hA3) begin
            errors++; $display("FAIL rst_line_words: miss %b data %h want 0/a3", miss, d);
        end
    endtask

    task automatic test_random(input bit lru);
        logic [31:0] d; logic vld; bit miss, bad, exp_hit; logic [29:0] ma, a;
        int unsigned t, s, o;
        int exp_h = 0, exp_m = 0;
        sel(lru);
        do_reset();
        for (int i = 0; i < SETS; i++) mq[i].delete();
        for (int n = 0; n < 120; n++) begin
            t = $urandom_range(0, 3); s = $urandom_range(0, SETS - 1); o = $urandom_range(0, LINE - 1);
            a = 30'(t * 32 + s * 8 + o);
            exp_hit = model_access(lru, int'(s), t);
            if (exp_hit) exp_h++; else exp_m++;
            fetch(a, -1, 1'b1, d, vld, miss, ma, bad);
            checks++;
            if (miss !== !exp_hit || vld !== 1'b1 || d !== mem_word(a)) begin
                errors++; $display("FAIL rand_%0d[%0d] addr %h: miss %b valid %b data %h want %b/1/%h",
                                   lru, n, a, miss, vld, d, !exp_hit, mem_word(a));
            end
            if (miss) begin
                checks++;
                if (ma !== {a[29:3], 3'b000} || bad) begin
                    errors++; $display("FAIL rand_refill_%0d[%0d]: mem_addr %h bad %b want %h/0",
                                       lru, n, ma, bad, {a[29:3], 3'b000});
                end
            end
        end
        checks++;
        if (cur_hits() !== 32'(exp_h) || cur_miss() !== 32'(exp_m)) begin
            errors++; $display("FAIL rand_counts_%0d: hit %0d miss %0d want %0d/%0d",
                               lru, cur_hits(), cur_miss(), exp_h, exp_m);
        end
    endtask

    initial begin
        idle_inputs();
        sel(1'b0);
        test_reset();
        test_miss_refill();
        test_back_to_back();
        test_fifo();
        test_flush_idle();
        test_lru();
        test_flush_refill();
        test_reset_mid_refill();
        test_random(1'b0);
        test_random(1'b1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_setassoc.md
Name: icache_setassoc

Overview:
Parametrised N-way set-associative instruction cache. It is the successor to the flat preloaded instruction store: it sits between the IF stage and a word-serial main-memory port. Hits return in one cycle. Misses stall the fetch, refill a whole line from memory, then return the word. It adds selectable FIFO/LRU replacement, whole-cache flush for fence.i/debug reload, and hit/miss counters.

Parameters:
LINE_ADDR_LEN, 3, log2 words per line (default 8 words)
SET_ADDR_LEN, 2, log2 number of sets (default 4)
WAY_CNT, 2, ways per set (power of two, 1..8)
SWAP_POLICY, 0, 0 = FIFO, 1 = LRU
CNT_WIDTH, 32, width of hit/miss counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
rd_req  in  1  fetch request, sampled when stall=0
addr  in  30  word address [31:2]
flush  in  1  invalidate all lines (one-cycle pulse)
rd_data  out  32  fetched instruction
rd_valid  out  1  rd_data valid this cycle
stall  out  1  cache busy; IF must hold addr/rd_req
mem_rd_req  out  1  line refill request, level
mem_addr  out  30  line-aligned word address of refill
mem_rvalid  in  1  one refill word valid
mem_rdata  in  32  refill word, ascending word order
hit_cnt  out  CNT_WIDTH  accepted requests that hit
miss_cnt  out  CNT_WIDTH  accepted requests that missed

Behaviour:
- Address split: word_off = addr[LINE_ADDR_LEN-1:0]; set = next SET_ADDR_LEN bits; tag = remaining 30-LINE_ADDR_LEN-SET_ADDR_LEN bits.
- Storage: data/tag/valid arrays as registers; the tag compare is combinational on addr.
- Reset (async, rst_n=0): all valid bits 0; FSM=IDLE; rd_valid=0; rd_data=0; mem_rd_req=0; mem_addr=0; stall=0; counters=0; FIFO pointers and LRU ages=0. Data/tag arrays are not reset.
- FSM states: IDLE, REFILL, RESP.
- IDLE, rd_req=1, flush=0, hit:
  - rd_data <= hit word; rd_valid=1 the next cycle (latency 1).
  - hit_cnt+1; under LRU, set the hit way's age to 0 and age every other way whose age was below the hit way's old age.
  - Back-to-back hits are accepted every cycle.
- IDLE, rd_req=1, miss:
  - stall=1 combinationally in the same cycle; miss_cnt+1.
  - Latch addr; go to REFILL; mem_rd_req<=1; mem_addr <= {tag,set,LINE_ADDR_LEN'b0}.
- REFILL:
  - stall=1.
  - Each mem_rvalid writes mem_rdata to word index k (k = 0..2^LINE_ADDR_LEN-1) of the victim way.
  - On the last word: write tag, set valid, update replacement, drop mem_rd_req, go to RESP.
  - mem_rvalid outside REFILL is ignored.
- RESP: rd_data = requested word; rd_valid=1; stall=1 for this cycle only; next state IDLE. A request is accepted again the following cycle.
- Victim selection: lowest-index invalid way. If none is invalid, FIFO uses the per-set round-robin pointer (incremented on fill, wraps at WAY_CNT); LRU uses the way with age WAY_CNT-1. After a fill, the filled way's age is 0 and all others are incremented, saturating at WAY_CNT-1.
- Flush:
  - In IDLE, clear all valid bits in one cycle, with stall=1 that cycle.
  - flush has priority over a simultaneous rd_req: the request is not accepted and not counted, and IF re-presents it.
  - flush during REFILL/RESP is latched; the refill completes, RESP returns the word, then the flush is applied (one extra stall cycle) before IDLE accepts requests.
- rd_valid is 0 in every cycle not listed above. rd_data holds its last value when rd_valid=0.
- Counters wrap modulo 2^CNT_WIDTH.
- Reset mid-refill: the refill is abandoned and mem_rd_req drops immediately. The memory side must tolerate a dropped request.
- WAY_CNT=1 degenerates to direct-mapped; replacement state is unused.

Decomposition:
- Shared package: SWAP_FIFO/SWAP_LRU constants, FSM state enum, derived widths (TAG_LEN, LINE_SIZE, SET_SIZE) as functions of the parameters.
- One natural sub-module: icache_repl, the per-set FIFO/LRU victim selector and updater, with inputs set, hit_way, fill_way, update strobes and output victim_way.

Test Plan:
1. Reset, then fetch addr 0x10 → stall=1 same cycle; mem_addr=0x10; 8 mem_rvalid words 0xA0..0xA7; RESP returns rd_data=0xA0; miss_cnt=1.
2. After scenario 1, fetch 0x11..0x17 back-to-back → 7 hits, rd_valid each cycle with latency 1, data 0xA1..0xA7; hit_cnt=7; no mem_rd_req.
3. FIFO, set 0: fill tags A, B, then C → C evicts A. Re-fetch A → miss. Re-fetch B → miss under FIFO (it was evicted by A's refill).
4. LRU: fill A, B; hit A; miss C → B evicted. Re-fetch A → hit.
5. flush pulse concurrent with rd_req in IDLE → no acceptance, counters unchanged. A later fetch of a previously cached line → miss.
6. Assert rst_n=0 after the 3rd refill word → mem_rd_req=0, stall=0 immediately. After release, the same fetch misses again and refills from word 0.
